// File: rtl/odd_even_count_checker.sv
// Watches an upstream even/odd step-by-two counter and checks each sample against
// the value predicted from the previous sample. Faults are counted and latched until clear.
module odd_even_count_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       odd_even,
    input  logic       enable,
    input  logic       cnt_rst,
    input  logic [3:0] count,
    input  logic       clear,
    output logic       locked,
    output logic       mismatch,
    output logic [7:0] err_count,
    output logic       sticky_err,
    output logic [3:0] expected
);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] TRACK    = 2'd1;
    localparam logic [1:0] FAULT    = 2'd2;

    logic [1:0] state;
    logic [3:0] prev_count;
    logic       prev_en;
    logic       prev_mode;
    logic [3:0] pred;
    logic       samp_err;
    logic       resync;

    // 4-bit add wraps 14->0 and 15->1, so both wrap points are legal predictions
    assign pred     = prev_en ? prev_count + 4'd2 : prev_count;
    assign samp_err = (count != pred) || (count[0] != odd_even);
    assign resync   = cnt_rst || (odd_even != prev_mode);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= UNLOCKED;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            err_count  <= 8'd0;
            sticky_err <= 1'b0;
            expected   <= 4'd0;
            prev_count <= 4'd0;
            prev_en    <= 1'b0;
            prev_mode  <= 1'b0;
        end else begin
            prev_count <= count;
            prev_en    <= enable;
            prev_mode  <= odd_even;
            mismatch   <= 1'b0;
            if (clear) begin
                state      <= UNLOCKED;
                locked     <= 1'b0;
                err_count  <= 8'd0;
                sticky_err <= 1'b0;
            end else if (state != FAULT && resync) begin
                // legal restart or mode switch: drop the lock silently
                state  <= UNLOCKED;
                locked <= 1'b0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        locked <= 1'b0;
                        if (count[0] == odd_even)
                            state <= TRACK;
                    end
                    TRACK: begin
                        expected <= pred;
                        if (samp_err) begin
                            mismatch   <= 1'b1;
                            sticky_err <= 1'b1;
                            locked     <= 1'b0;
                            state      <= FAULT;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 8'd1;
                        end else begin
                            locked <= 1'b1;
                        end
                    end
                    default: begin
                        // FAULT (and the unused encoding) waits for clear
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
